// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency IMEM, presents one instruction per cycle.
// Optional FETCH_STATS_EN macro adds fetch_count / bubble_count outputs.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] hold_q;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign pc_inc       = pc_f + 32'd4;

  // Address/enable are combinational so a redirect reaches IMEM in the same cycle.
  always_comb begin
    imem_addr = pc_f;
    imem_en   = 1'b0;
    if (redirect_valid) begin
      imem_addr = redirect_tgt;
      imem_en   = 1'b1;
    end else begin
      case (state)
        BOOT: imem_en = 1'b1;
        RUN, HOLD: begin
          if (!stall) begin
            imem_addr = pc_inc;
            imem_en   = 1'b1;
          end
        end
        default: imem_en = 1'b0;
      endcase
    end
  end

  // The instruction fetched during a redirect cycle is on the wrong path.
  assign instr_valid = (state != BOOT) && !redirect_valid;
  assign instr_pc    = pc_f;
  assign instr       = !instr_valid     ? NOP_INSTR :
                       (state == HOLD)  ? hold_q    : imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BOOT;
      pc_f   <= RESET_PC;
      hold_q <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc_f  <= redirect_tgt;
      state <= RUN;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (stall) begin
            hold_q <= imem_rdata;
            state  <= HOLD;
          end else begin
            pc_f <= pc_inc;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_f  <= pc_inc;
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (instr_valid && !stall)
        fetch_count <= fetch_count + 32'd1;
      if (!instr_valid && (state != BOOT))
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule
